// File: rtl/ovl_fabric_cfg_ctrl.sv
// rtl/ovl_fabric_cfg_ctrl.sv - configuration, run/pause sequencing and alarm capture for a chain of checker slots
module ovl_fabric_cfg_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_slot,
    input  logic [1:0]             cfg_select,
    input  logic [2:0]             cfg_num_cks,
    input  logic                   cfg_commit,
    input  logic                   run_req,
    output logic [2*NUM_SLOTS-1:0] slot_select,
    output logic [3*NUM_SLOTS-1:0] slot_num_cks,
    output logic                   slot_enable,
    output logic                   slot_rst,
    input  logic [NUM_SLOTS-1:0]   slot_out,
    input  logic                   chain_cfg_invalid,
    output logic [2:0]             state,
    output logic                   alarm,
    output logic [2:0]             alarm_slot,
    output logic [CNT_W-1:0]       alarm_count,
    output logic                   err_cfg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [2*NUM_SLOTS-1:0] sh_sel_q, act_sel_q;
    logic [3*NUM_SLOTS-1:0] sh_cks_q, act_cks_q;
    logic                   alarm_q, err_cfg_q;
    logic [2:0]             alarm_slot_q, first_idx;
    logic [CNT_W-1:0]       alarm_count_q;
    logic                   wr_fire, any_fire;

    assign cfg_ready   = (state_q == IDLE) || (state_q == PAUSE);
    assign slot_enable = (state_q == RUN);
    // Checkers are held in reset for the whole time the controller is.
    assign slot_rst    = !rst || (state_q == CLEAR);
    assign wr_fire     = cfg_valid && cfg_ready;
    assign any_fire    = |slot_out;

    assign state        = state_q;
    assign slot_select  = act_sel_q;
    assign slot_num_cks = act_cks_q;
    assign alarm        = alarm_q;
    assign alarm_slot   = alarm_slot_q;
    assign alarm_count  = alarm_count_q;
    assign err_cfg      = err_cfg_q;

    always_comb begin
        first_idx = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_out[i]) first_idx = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cfg_commit) state_d = CLEAR;
            CLEAR: state_d = CHECK;
            CHECK: begin
                if (chain_cfg_invalid) state_d = IDLE;
                else if (run_req)      state_d = RUN;
                else                   state_d = PAUSE;
            end
            RUN:   if (!run_req) state_d = PAUSE;
            PAUSE: begin
                if (cfg_commit)   state_d = CLEAR;
                else if (run_req) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sh_sel_q      <= {NUM_SLOTS{2'd2}};
            sh_cks_q      <= {NUM_SLOTS{3'd1}};
            act_sel_q     <= {NUM_SLOTS{2'd2}};
            act_cks_q     <= {NUM_SLOTS{3'd1}};
            alarm_q       <= 1'b0;
            alarm_slot_q  <= 3'd0;
            alarm_count_q <= '0;
            err_cfg_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_fire) begin
                if (32'(cfg_slot) < NUM_SLOTS) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (cfg_slot == 3'(i)) begin
                            sh_sel_q[2*i +: 2] <= cfg_select;
                            sh_cks_q[3*i +: 3] <= cfg_num_cks;
                        end
                    end
                end else begin
                    err_cfg_q <= 1'b1;
                end
            end
            case (state_q)
                CLEAR: begin
                    act_sel_q     <= sh_sel_q;
                    act_cks_q     <= sh_cks_q;
                    alarm_q       <= 1'b0;
                    alarm_slot_q  <= 3'd0;
                    alarm_count_q <= '0;
                    err_cfg_q     <= 1'b0;
                end
                CHECK: if (chain_cfg_invalid) err_cfg_q <= 1'b1;
                RUN: begin
                    if (any_fire) begin
                        alarm_q <= 1'b1;
                        if (!alarm_q) alarm_slot_q <= first_idx;
                        if (alarm_count_q != {CNT_W{1'b1}}) alarm_count_q <= alarm_count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
